// File: rtl/sub32_pkg.sv
// Shared types and constants for the byte-serial 32-bit subtractor.
// The result is built one 8-bit slice per clock, least significant slice first.
package sub32_pkg;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NSLICE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] slice_idx_t;

    localparam slice_idx_t LAST_SLICE = slice_idx_t'(NSLICE - 1);

    // Bit position of the low end of slice i inside a 32-bit word.
    function automatic logic [4:0] slice_lsb(input slice_idx_t i);
        return {i, 3'b000};
    endfunction

endpackage

// File: rtl/sub8_slice.sv
// One 8-bit subtract slice with borrow in and borrow out.
// Purely combinational.
module sub8_slice (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       bin,
    output logic [7:0] d,
    output logic       bout
);

    logic [8:0] diff9;

    // The ninth bit of the widened difference is the borrow out of this slice.
    assign diff9 = {1'b0, a} - {1'b0, b} - {8'b0, bin};
    assign d     = diff9[7:0];
    assign bout  = diff9[8];

endmodule

// File: rtl/sub32_serial.sv
// Byte-serial 32-bit subtractor: minuend - subtrahend over four clocks,
// with borrow, zero and signed-overflow flags and a start/busy/done handshake.
module sub32_serial
    import sub32_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [31:0] minuend,
    input  logic [31:0] subtrahend,
    output logic        busy,
    output logic        done,
    output logic [31:0] difference,
    output logic        borrow,
    output logic        zero,
    output logic        overflow
);

    state_t                  state;
    state_t                  state_next;
    slice_idx_t              idx;
    logic                    bin;
    logic                    accept;
    logic                    last;

    logic [WIDTH-1:0]        a_reg;
    logic [WIDTH-1:0]        b_reg;
    logic [WIDTH-SLICE-1:0]  work;

    logic [SLICE-1:0]        slice_a;
    logic [SLICE-1:0]        slice_b;
    logic [SLICE-1:0]        slice_d;
    logic                    slice_bout;
    logic [WIDTH-1:0]        result;

    // Two's-complement overflow of a - b: operands differ in sign and the
    // result sign differs from the minuend.
    function automatic logic sub_overflow(input logic a_msb, input logic b_msb,
                                          input logic d_msb);
        return (a_msb ^ b_msb) & (a_msb ^ d_msb);
    endfunction

    assign slice_a = a_reg[slice_lsb(idx) +: SLICE];
    assign slice_b = b_reg[slice_lsb(idx) +: SLICE];
    assign last    = (idx == LAST_SLICE);

    // On the final slice the top byte comes straight from the slice so the
    // full result is available on the same edge it is registered.
    assign result  = {slice_d, work};

    sub8_slice u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .bin  (bin),
        .d    (slice_d),
        .bout (slice_bout)
    );

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            bin        <= 1'b0;
            difference <= '0;
            borrow     <= 1'b0;
            zero       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                idx <= '0;
                bin <= 1'b0;
            end else if (state == RUN) begin
                idx <= idx + 2'd1;
                bin <= slice_bout;
            end
            if ((state == RUN) && last) begin
                difference <= result;
                borrow     <= slice_bout;
                zero       <= (result == '0);
                overflow   <= sub_overflow(a_reg[WIDTH-1], b_reg[WIDTH-1], slice_d[SLICE-1]);
            end
        end
    end

    // Operand and partial-result storage carries no reset; control decides
    // when its contents are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= minuend;
            b_reg <= subtrahend;
        end
        if (state == RUN) begin
            case (idx)
                2'd0:    work[7:0]   <= slice_d;
                2'd1:    work[15:8]  <= slice_d;
                2'd2:    work[23:16] <= slice_d;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub32_serial.sv
// Scoreboard bench for sub32_serial: directed operations push expected
// results, a monitor pops and compares on every done pulse.
module tb_sub32_serial;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] minuend = '0;
    logic [31:0] subtrahend = '0;
    logic        busy;
    logic        done;
    logic [31:0] difference;
    logic        borrow;
    logic        zero;
    logic        overflow;

    typedef struct {
        logic [31:0] d;
        logic        bo;
        logic        z;
        logic        ov;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   errors  = 0;
    int   checks  = 0;
    int   cyc     = 0;
    int   run_len = 0;

    sub32_serial dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .busy       (busy),
        .done       (done),
        .difference (difference),
        .borrow     (borrow),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_op(input logic [31:0] d, input logic bo, input logic z,
                             input logic ov);
        exp_t e;
        e.d   = d;
        e.bo  = bo;
        e.z   = z;
        e.ov  = ov;
        e.acc = cyc + 1;
        sb.push_back(e);
    endtask

    // One isolated operation; operands are scrambled right after capture.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] d,
                         input logic bo, input logic z, input logic ov);
        @(negedge clk);
        start      = 1'b1;
        minuend    = a;
        subtrahend = b;
        expect_op(d, bo, z, ov);
        @(negedge clk);
        start      = 1'b0;
        minuend    = ~a;
        subtrahend = b ^ 32'h5A5A_5A5A;
        repeat (5) @(negedge clk);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (busy) run_len++;
        else if (!done) run_len = 0;
        if (done) begin
            chk("done_with_busy", {31'b0, busy}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got difference %h with no operation pending", difference);
            end else begin
                e = sb.pop_front();
                chk("difference", difference, e.d);
                chk("borrow", {31'b0, borrow}, {31'b0, e.bo});
                chk("zero", {31'b0, zero}, {31'b0, e.z});
                chk("overflow", {31'b0, overflow}, {31'b0, e.ov});
                chk("latency", 32'(cyc), 32'(e.acc + 4));
                chk("busy_cycles", 32'(run_len), 32'd4);
            end
            run_len = 0;
        end
    end

    initial begin
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_difference", difference, 32'd0);
        chk("rst_flags", {29'b0, borrow, zero, overflow}, 32'd0);
        reset_n = 1'b1;

        issue(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        issue(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1);
        issue(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b1, 1'b0);
        issue(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);
        issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1);

        // Start pulse with new operands in the second RUN cycle must be ignored.
        @(negedge clk);
        start      = 1'b1;
        minuend    = 32'h0000_0100;
        subtrahend = 32'h0000_0001;
        expect_op(32'h0000_00FF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start      = 1'b1;
        minuend    = 32'hDEAD_BEEF;
        subtrahend = 32'h0000_0000;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);

        // Start held high: three back-to-back operations, one every 5 cycles.
        @(negedge clk);
        start      = 1'b1;
        minuend    = 32'h0000_000A;
        subtrahend = 32'h0000_0003;
        expect_op(32'h0000_0007, 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        minuend    = 32'h0000_0003;
        subtrahend = 32'h0000_000A;
        expect_op(32'hFFFF_FFF9, 1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        minuend    = 32'hFFFF_FFFF;
        subtrahend = 32'hFFFF_FFFF;
        expect_op(32'h0000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        start      = 1'b0;
        minuend    = 32'h1111_1111;
        subtrahend = 32'h2222_2222;
        repeat (5) @(negedge clk);

        // Leave non-zero outputs behind, then abort an operation mid-RUN.
        issue(32'h0000_0001, 32'h8000_0002, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        start      = 1'b1;
        minuend    = 32'h0000_0009;
        subtrahend = 32'h0000_0004;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        start   = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_difference", difference, 32'd0);
        chk("abort_flags", {29'b0, borrow, zero, overflow}, 32'd0);
        @(negedge clk);
        chk("abort_start_dropped", {31'b0, busy}, 32'd0);
        issue(32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sub32_serial.md
# sub32_serial

Byte-serial 32-bit subtractor; the multi-cycle counterpart to the combinational 32-bit adder in the lab datapath. It computes minuend − subtrahend one 8-bit slice per clock, rippling the borrow through a single registered borrow bit. Results come with unsigned-borrow, zero and signed-overflow flags. It sits beside the adder in the ALU and uses a start/busy/done handshake.

## Interface
Parameters: none; width is fixed at 32 bits, processed as 4 × 8-bit slices.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request; sampled only when accepting
- minuend  in  32  operand A; captured on accepted start
- subtrahend  in  32  operand B; captured on accepted start
- busy  out  1  high while slices are in progress
- done  out  1  one-cycle completion pulse
- difference  out  32  A − B mod 2^32; held until next completion
- borrow  out  1  final borrow-out; 1 iff A < B unsigned
- zero  out  1  difference == 0
- overflow  out  1  signed overflow of A − B

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE: accepting. When start=1, capture A and B, clear the working borrow, set slice index idx=0, go to RUN.
  - RUN: one slice per cycle.
    - d[8i+7:8i] = A[8i+7:8i] − B[8i+7:8i] − bin, written into the working register.
    - bin ← slice borrow-out.
    - idx wraps 3→0; on the idx=3 edge, go to DONE.
  - DONE: one cycle long, done=1, then back to IDLE.
- Start acceptance:
  - DONE also accepts start. An accepted start there goes straight to RUN, which allows back-to-back operations.
  - start in RUN is ignored and has no side effects.
- Slice arithmetic: 9-bit difference {bout, d8} = {1'b0, a8} − {1'b0, b8} − bin.
- Output registers (difference, borrow, zero, overflow):
  - Load only on the RUN→DONE edge, all on that same edge.
  - Intermediate slice values are never visible on the outputs.
- overflow = (A[31] ^ B[31]) & (A[31] ^ D[31]), using the captured operands.
- Operand inputs may change freely after capture; the in-flight result is unaffected.

## Timing
- Start is accepted at edge 0. Slices 0–3 are computed at edges 1–4. done=1 in the cycle following edge 4.
- Latency is 4 cycles from the accepting edge to done.
- Throughput is one operation per 5 cycles. With start held high continuously, back-to-back results come every 5 cycles.
- busy=1 exactly in the RUN cycles, which is 4 cycles per operation.
- done is never high together with busy.
- Reset (reset_n=0 at a rising edge), at any state including mid-RUN:
  - Go to IDLE, abort the in-flight operation, idx=0.
  - busy=0, done=0, difference=0, borrow=0, zero=0, overflow=0. zero resets to 0 even though difference is 0.
  - A start sampled in the same cycle as reset is dropped.

## Structure
- Package sub32_pkg:
  - state enum {IDLE, RUN, DONE}
  - localparam WIDTH=32, SLICE=8, NSLICE=4
  - a 2-bit slice-index type
- Sub-module sub8_slice: combinational; inputs a[7:0], b[7:0], bin; outputs d[7:0], bout.
- Exactly one sub8_slice instance, fed by idx-selected operand bytes.
- The top level holds the FSM, operand/working registers, borrow flop and output registers.

## Test plan
- Reset, then 0x00000005 − 0x00000003:
  - difference=0x00000002, borrow=0, zero=0, overflow=0.
  - done exactly 4 cycles after the accepting edge; busy high for 4 cycles.
- 0x00000000 − 0x00000001 → difference=0xFFFFFFFF, borrow=1, zero=0, overflow=0. Borrow ripples through all 4 slices.
- 0x80000000 − 0x00000001 → 0x7FFFFFFF, overflow=1, borrow=0.
- 0x12345678 − 0x12345678 → 0x00000000, zero=1, borrow=0. Then 0x00010000 − 0x00000001 → 0x0000FFFF, borrow=0, zero=0.
- Handshake:
  - A second start pulse with different operands during RUN is ignored; the first result is unchanged.
  - start held high continuously gives done every 5 cycles.
  - Operand change after capture has no effect on the result.
- Reset mid-operation: assert reset_n=0 in the 2nd RUN cycle.
  - Next cycle: IDLE, all outputs 0, no done pulse.
  - A new start then completes normally with a correct result.
